// File: rtl/hazard_controller_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
package hazard_controller_pkg;

  localparam int unsigned REG_W = 5;

  typedef enum logic [0:0] {
    HC_RUN      = 1'b0,
    HC_MEM_WAIT = 1'b1
  } hcState_t;

  // Load in EX whose non-x0 destination feeds either source of the instruction in ID.
  function automatic logic isLoadUse(input logic memRead, input logic [REG_W-1:0] rd,
                                     input logic [REG_W-1:0] rs1, input logic [REG_W-1:0] rs2);
    return memRead && (rd != '0) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/hazard_controller_sat_counter.sv
// Up-counter that sticks at its all-ones value; asynchronous active-high clear.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Freezes, bubbles and flushes the 5-stage pipeline for load-use, taken
// branches in MEM and multi-cycle data-memory accesses with a timeout.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IF_ID_RegisterRs1,
  input  logic [4:0]       IF_ID_RegisterRs2,
  input  logic [4:0]       ID_EX_RegisterRd,
  input  logic             ID_EX_MemRead,
  input  logic             EX_MEM_MemAccess,
  input  logic             EX_MEM_BranchTaken,
  input  logic             dmem_ack,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             mem_wb_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             dmem_req,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned WCNT_W = $clog2(TIMEOUT + 1);

  hcState_t          state, nextState;
  logic [WCNT_W-1:0] wcnt, nextWcnt;
  logic              advance;
  logic              allWrite;

  // State and wait-counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= HC_RUN;
      wcnt  <= '0;
    end else begin
      state <= nextState;
      wcnt  <= nextWcnt;
    end
  end

  // Mealy next-state and sequencing outputs; reset forces the idle defaults.
  always_comb begin
    nextState    = state;
    nextWcnt     = wcnt;
    advance      = 1'b1;
    allWrite     = 1'b1;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    dmem_req     = 1'b0;
    mem_error    = 1'b0;

    if (rst) begin
      advance = 1'b0;
    end else begin
      unique case (state)
        HC_RUN: begin
          if (EX_MEM_MemAccess) begin
            dmem_req = 1'b1;
            if (!dmem_ack) begin
              advance   = 1'b0;
              allWrite  = 1'b0;
              nextState = HC_MEM_WAIT;
              nextWcnt  = WCNT_W'(1);
            end
          end
        end
        HC_MEM_WAIT: begin
          dmem_req = 1'b1;
          // wcnt holds the number of request cycles already spent waiting.
          if (dmem_ack) begin
            nextState = HC_RUN;
            nextWcnt  = '0;
          end else if (wcnt == WCNT_W'(TIMEOUT - 1)) begin
            mem_error = 1'b1;
            nextState = HC_RUN;
            nextWcnt  = '0;
          end else begin
            advance  = 1'b0;
            allWrite = 1'b0;
            nextWcnt = wcnt + WCNT_W'(1);
          end
        end
        default: begin
          nextState = HC_RUN;
          nextWcnt  = '0;
        end
      endcase
    end

    pc_write    = allWrite;
    if_id_write = allWrite;

    if (advance) begin
      if (EX_MEM_BranchTaken) begin
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
      end else if (isLoadUse(ID_EX_MemRead, ID_EX_RegisterRd,
                             IF_ID_RegisterRs1, IF_ID_RegisterRs2)) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  assign id_ex_write  = allWrite;
  assign ex_mem_write = allWrite;
  assign mem_wb_write = allWrite;

  sat_counter #(.CNT_W(CNT_W)) uStallCnt (
    .clk   (clk),
    .rst   (rst),
    .en    (!pc_write),
    .count (stall_cycles)
  );

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller with hand-computed expectations.
module tb_hazard_controller;

  localparam int unsigned TIMEOUT = 4;
  localparam int unsigned CNT_W   = 4;

  // {pc,if_id,id_ex,ex_mem,mem_wb write, if_id,id_ex,ex_mem flush, dmem_req, mem_error}
  localparam logic [9:0] ADV     = 10'b11111_000_00;
  localparam logic [9:0] ADV_REQ = 10'b11111_000_10;
  localparam logic [9:0] FROZEN  = 10'b00000_000_10;
  localparam logic [9:0] LU      = 10'b00111_010_00;
  localparam logic [9:0] BR      = 10'b11111_111_00;
  localparam logic [9:0] BR_REQ  = 10'b11111_111_10;
  localparam logic [9:0] TMO     = 10'b11111_000_11;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       rs1, rs2, rd;
  logic             memRead, memAccess, branchTaken, ack;
  logic             pcWrite, ifIdWrite, idExWrite, exMemWrite, memWbWrite;
  logic             ifIdFlush, idExFlush, exMemFlush, dmemReq, memError;
  logic [CNT_W-1:0] stallCycles;
  logic [9:0]       ctl;

  int testCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  hazard_controller #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk                (clk),
    .rst                (rst),
    .IF_ID_RegisterRs1  (rs1),
    .IF_ID_RegisterRs2  (rs2),
    .ID_EX_RegisterRd   (rd),
    .ID_EX_MemRead      (memRead),
    .EX_MEM_MemAccess   (memAccess),
    .EX_MEM_BranchTaken (branchTaken),
    .dmem_ack           (ack),
    .pc_write           (pcWrite),
    .if_id_write        (ifIdWrite),
    .id_ex_write        (idExWrite),
    .ex_mem_write       (exMemWrite),
    .mem_wb_write       (memWbWrite),
    .if_id_flush        (ifIdFlush),
    .id_ex_flush        (idExFlush),
    .ex_mem_flush       (exMemFlush),
    .dmem_req           (dmemReq),
    .mem_error          (memError),
    .stall_cycles       (stallCycles)
  );

  assign ctl = {pcWrite, ifIdWrite, idExWrite, exMemWrite, memWbWrite,
                ifIdFlush, idExFlush, exMemFlush, dmemReq, memError};

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic setIn(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                       input logic mr, input logic ma, input logic br, input logic ak);
    rs1 = s1; rs2 = s2; rd = d;
    memRead = mr; memAccess = ma; branchTaken = br; ack = ak;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    setIn(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkVal("reset_outputs", 32'(ctl), 32'(ADV));
    checkVal("reset_stall", 32'(stallCycles), 32'd0);
    setIn(5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    checkVal("reset_forced", 32'(ctl), 32'(ADV));
    step();
    rst = 1'b0;
    setIn(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkVal("idle", 32'(ctl), 32'(ADV));

    // lw x5 in EX, add x6,x5,x1 in ID
    setIn(5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    checkVal("loaduse_rs1", 32'(ctl), 32'(LU));
    step();
    setIn(5'd6, 5'd1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkVal("loaduse_after", 32'(ctl), 32'(ADV));
    checkVal("loaduse_stall", 32'(stallCycles), 32'd1);

    setIn(5'd0, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkVal("loaduse_x0", 32'(ctl), 32'(ADV));
    setIn(5'd7, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    checkVal("no_load_match", 32'(ctl), 32'(ADV));
    step();
    checkVal("x0_stall", 32'(stallCycles), 32'd1);

    setIn(5'd3, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    checkVal("loaduse_rs2", 32'(ctl), 32'(LU));
    step();
    setIn(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkVal("rs2_stall", 32'(stallCycles), 32'd2);

    // branch outranks load-use
    setIn(5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    checkVal("branch_over_lu", 32'(ctl), 32'(BR));
    step();
    setIn(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkVal("branch_stall", 32'(stallCycles), 32'd2);

    // access with ack on 4th request cycle, branch held: flush deferred to ack
    setIn(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkVal("acc_c1", 32'(ctl), 32'(FROZEN));
    step();
    checkVal("acc_c2", 32'(ctl), 32'(FROZEN));
    step();
    checkVal("acc_c3", 32'(ctl), 32'(FROZEN));
    step();
    setIn(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    checkVal("acc_ack_branch", 32'(ctl), 32'(BR_REQ));
    step();
    setIn(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkVal("acc_done", 32'(ctl), 32'(ADV));
    checkVal("acc_stall", 32'(stallCycles), 32'd5);

    // zero-wait, then an immediate second access
    setIn(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkVal("zero_wait", 32'(ctl), 32'(ADV_REQ));
    step();
    setIn(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkVal("b2b_c1", 32'(ctl), 32'(FROZEN));
    checkVal("zero_wait_stall", 32'(stallCycles), 32'd5);
    step();
    setIn(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkVal("b2b_ack", 32'(ctl), 32'(ADV_REQ));
    step();
    setIn(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkVal("ack_ignored", 32'(ctl), 32'(ADV));
    checkVal("b2b_stall", 32'(stallCycles), 32'd6);
    step();

    // timeout: request high exactly TIMEOUT cycles, error in the last
    setIn(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkVal("tmo_c1", 32'(ctl), 32'(FROZEN));
    step();
    checkVal("tmo_c2", 32'(ctl), 32'(FROZEN));
    step();
    checkVal("tmo_c3", 32'(ctl), 32'(FROZEN));
    step();
    checkVal("tmo_c4", 32'(ctl), 32'(TMO));
    step();
    setIn(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkVal("tmo_after", 32'(ctl), 32'(ADV));
    checkVal("tmo_stall", 32'(stallCycles), 32'd9);

    // reset in the second wait cycle abandons the access
    setIn(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    checkVal("rstwait_c2", 32'(ctl), 32'(FROZEN));
    rst = 1'b1;
    #1;
    checkVal("rstwait_req", 32'(ctl), 32'(ADV));
    checkVal("rstwait_stall", 32'(stallCycles), 32'd0);
    step();
    rst = 1'b0;
    setIn(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkVal("rstwait_run", 32'(ctl), 32'(ADV));
    setIn(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkVal("rstwait_in_run", 32'(ctl), 32'(ADV_REQ));

    // stall counter saturates at 2^CNT_W-1
    setIn(5'd9, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step();
    checkVal("sat_stall", 32'(stallCycles), 32'd15);
    checkVal("sat_lu", 32'(ctl), 32'(LU));

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
